rx_timing_ctrl: RTL
===================

RX_TIMING_CTRL -- requirements
Module: rx_timing_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to begin one packet timing sequence.
REQ-004 SHALL have port abort, input, 1, cancel the sequence in progress.
REQ-005 SHALL have port bit_period, input, 4, clocks per bit (P); values 0..1 treated as 2.
REQ-006 SHALL have port num_bits, input, 4, data bits per packet (N); value 0 treated as 1.
REQ-007 SHALL have port shift_strobe, output, 1, one-cycle pulse at the centre of each data bit.
REQ-008 SHALL have port stop_strobe, output, 1, one-cycle pulse at the centre of the stop bit.
REQ-009 SHALL have port packet_done, output, 1, one-cycle pulse after stop_strobe.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port bit_index, output, 4, number of shift_strobes issued in the current packet.

Function
REQ-012 SHALL implement FSM states IDLE, HALF, BITS, STOP, DONE.
REQ-013 SHALL, in IDLE with start=1 and abort=0, latch P and N (after clamping) at that edge E0, clear both counters, and enter HALF.
REQ-014 SHALL ignore start outside IDLE; latched P and N SHALL NOT change until the next accepted start.
REQ-015 SHALL remain in HALF for H = P>>1 cycles, then enter BITS without strobing.
REQ-016 SHALL, in BITS, assert shift_strobe for exactly one cycle starting at edge E0+H+k*P for k = 1..N, and increment bit_index on the same edge.
REQ-017 SHALL enter STOP on the edge that issues strobe N, and assert stop_strobe for one cycle starting at edge E0+H+(N+1)*P.
REQ-018 SHALL enter DONE on the stop_strobe edge, assert packet_done for the following cycle only, then return to IDLE.
REQ-019 SHALL, on abort=1 in any state, enter IDLE at the next edge with busy=0, and issue no strobe or done pulse in that cycle or later.
REQ-020 SHALL give abort priority over start when both are high in the same cycle, including in IDLE.
REQ-021 SHALL clear bit_index on an accepted start; bit_index SHALL hold N from strobe N until the next accepted start or reset.
REQ-022 SHALL never assert shift_strobe, stop_strobe and packet_done in the same cycle.
REQ-023 SHALL accept start in the cycle after packet_done, so back-to-back packets are possible.

Reset
REQ-024 SHALL, while rst=1, force IDLE, clear both counters, and drive shift_strobe=0, stop_strobe=0, packet_done=0, busy=0, bit_index=0.
REQ-025 SHALL, when rst asserts mid-sequence, clear all outputs asynchronously with no further pulses, and accept a new start only after rst deasserts.

Structure
REQ-026 SHALL place the state encoding and constants MIN_PERIOD=2 and MIN_BITS=1 in shared package rx_timing_pkg.
REQ-027 SHALL reuse the team's 4-bit flex_counter (clk, n_rst, clear, count_enable, rollover_val, count_out, rollover_flag) for its counting.
REQ-028 SHALL use two flex_counter instances, one as cycle timer (rollover H, then P) and one as bit counter (rollover N).
REQ-029 SHALL drive each flex_counter n_rst from the inverted rst.

Verification
REQ-030 SHALL cover normal packet: P=4, N=8, start at E0 -> shift_strobe at E0+6, 10, ..., 34; stop_strobe at E0+38; packet_done at E0+39; busy low from E0+40.
REQ-031 SHALL cover clamping: P=1, N=0 -> behaves as P=2, N=1: shift_strobe at E0+3, stop_strobe at E0+5, packet_done at E0+6.
REQ-032 SHALL cover abort: P=4, N=8, abort at E0+12 -> IDLE at E0+13, bit_index=2, no further strobes.
REQ-033 SHALL cover config change and start while busy: change P to 15 and pulse start at E0+8 -> timing unchanged from REQ-030.
REQ-034 SHALL cover async reset: assert rst between clock edges at E0+20 -> all outputs 0 immediately; after release, start gives a full correct packet.
REQ-035 SHALL cover back-to-back packets: start in the cycle after packet_done -> second packet timing identical to the first.

Source files
------------

// File: rtl/rx_timing_pkg.sv
// Shared state encoding and configuration limits for the RX bit-timing controller.
package rx_timing_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HALF = 3'd1,
        BITS = 3'd2,
        STOP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] MIN_PERIOD = 4'd2;
    localparam logic [3:0] MIN_BITS   = 4'd1;

    function automatic logic [3:0] clamp_period(input logic [3:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        return (n < MIN_BITS) ? MIN_BITS : n;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// 4-bit up-counter: counts 1..rollover_val and wraps back to 1; clear forces 0.
module flex_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       count_enable,
    input  logic [3:0] rollover_val,
    output logic [3:0] count_out,
    output logic       rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= 4'd1;
            end else begin
                count_out <= count_out + 4'd1;
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/rx_timing_ctrl.sv
// Packet bit-timing sequencer: half-bit offset, N data-bit centre strobes, stop strobe, done pulse.
// state | meaning
// IDLE  | waiting for start
// HALF  | half-bit offset into the first data bit
// BITS  | one shift_strobe per bit period until N issued
// STOP  | waiting for centre of the stop bit
// DONE  | stop_strobe cycle, then packet_done cycle
module rx_timing_ctrl
    import rx_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] bit_period,
    input  logic [3:0] num_bits,
    output logic       shift_strobe,
    output logic       stop_strobe,
    output logic       packet_done,
    output logic       busy,
    output logic [3:0] bit_index
);

    state_t     state, state_next;
    logic [3:0] p_lat, n_lat, h_lat;
    logic       accept;
    logic       shift_next, stop_next, done_next;
    logic       n_rst;

    logic [3:0] t_count, t_roll;
    logic       t_flag, t_clear, t_en;
    logic       b_flag;

    assign n_rst  = ~rst;
    assign accept = (state == IDLE) && start && !abort;
    assign h_lat  = p_lat >> 1;
    assign busy   = (state != IDLE);

    // Timer starts counting on the accepting edge, so it reads j+1 at E0+j and
    // hits H exactly in the last HALF cycle; it then wraps to 1 and runs at P.
    assign t_roll  = ((state == BITS) || (state == STOP)) ? p_lat : h_lat;
    assign t_clear = abort || (state == DONE) || ((state == IDLE) && !start);
    assign t_en    = accept || (state == HALF) || (state == BITS) || (state == STOP);

    flex_counter u_cycle_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (t_clear),
        .count_enable  (t_en),
        .rollover_val  (t_roll),
        .count_out     (t_count),
        .rollover_flag (t_flag)
    );

    flex_counter u_bit_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (accept),
        .count_enable  (shift_next),
        .rollover_val  (n_lat),
        .count_out     (bit_index),
        .rollover_flag (b_flag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_strobe <= 1'b0;
            stop_strobe  <= 1'b0;
            packet_done  <= 1'b0;
            p_lat        <= MIN_PERIOD;
            n_lat        <= MIN_BITS;
        end else begin
            state        <= state_next;
            shift_strobe <= shift_next;
            stop_strobe  <= stop_next;
            packet_done  <= done_next;
            if (accept) begin
                p_lat <= clamp_period(bit_period);
                n_lat <= clamp_bits(num_bits);
            end
        end
    end

    always_comb begin
        state_next = state;
        shift_next = 1'b0;
        stop_next  = 1'b0;
        done_next  = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_next = HALF;
                end
                HALF: begin
                    if (t_flag) state_next = BITS;
                end
                BITS: begin
                    if (t_flag) begin
                        shift_next = 1'b1;
                        if (bit_index == n_lat - 4'd1) state_next = STOP;
                    end
                end
                STOP: begin
                    if (t_flag && b_flag) begin
                        stop_next  = 1'b1;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    // first DONE cycle carries stop_strobe, second carries packet_done
                    if (packet_done) begin
                        state_next = IDLE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
